// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the OV7670 configuration path: ROM sentinels,
// sequencer state encoding and the {reg, val} entry layout.
package cam_cfg_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    localparam int ENTRY_REG_MSB = 15;
    localparam int ENTRY_REG_LSB = 8;
    localparam int ENTRY_VAL_MSB = 7;
    localparam int ENTRY_VAL_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DELAY     = 3'd6,
        ST_DONE      = 3'd7
    } cfg_state_t;

    function automatic logic [7:0] entry_reg(input logic [15:0] entry);
        return entry[ENTRY_REG_MSB:ENTRY_REG_LSB];
    endfunction

    function automatic logic [7:0] entry_val(input logic [15:0] entry);
        return entry[ENTRY_VAL_MSB:ENTRY_VAL_LSB];
    endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// Settle-delay down-counter: load a start value, decrement to zero and hold.
module cfg_delay_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_sysclk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the camera register ROM and issues one SCCB write per entry, with a
// settle delay on the delay sentinel and a done level on the end sentinel.
module ov7670_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 1_000_000
) (
    input  logic              i_sysclk,
    input  logic              i_rstn,
    input  logic              i_cfg_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_valid,
    input  logic              i_sccb_ready,
    output logic [7:0]        o_sccb_reg,
    output logic [7:0]        o_sccb_val,
    input  logic              i_sccb_done,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                CNT_W      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR  = '1;

    cfg_state_t        state, state_n;
    logic [ROM_AW-1:0] addr_n;
    logic [15:0]       entry, entry_n;
    logic [7:0]        reg_n, val_n;
    logic              advance;
    logic              cnt_load, cnt_zero;

    cfg_delay_counter #(
        .WIDTH(CNT_W)
    ) u_delay (
        .i_sysclk  (i_sysclk),
        .i_rstn    (i_rstn),
        .i_load    (cnt_load),
        .i_load_val(DELAY_LOAD),
        .i_dec     (state == ST_DELAY),
        .o_zero    (cnt_zero)
    );

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state;
        addr_n   = o_rom_addr;
        entry_n  = entry;
        reg_n    = o_sccb_reg;
        val_n    = o_sccb_val;
        cnt_load = 1'b0;
        advance  = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_cfg_start) begin
                    addr_n  = '0;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH:  state_n = ST_LATCH;
            ST_LATCH: begin
                entry_n = i_rom_data;
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                if (entry == CFG_END) begin
                    state_n = ST_DONE;
                end else if (entry == CFG_DELAY) begin
                    cnt_load = 1'b1;
                    state_n  = ST_DELAY;
                end else begin
                    reg_n   = entry_reg(entry);
                    val_n   = entry_val(entry);
                    state_n = ST_SEND;
                end
            end
            // A done pulse seen here belongs to no transfer of ours and is dropped.
            ST_SEND:      if (i_sccb_ready) state_n = ST_WAIT_DONE;
            ST_WAIT_DONE: advance = i_sccb_done;
            ST_DELAY:     advance = cnt_zero;
            default:      state_n = ST_IDLE;
        endcase

        // The last ROM slot ends the table even without a sentinel; no wrap.
        if (advance) begin
            if (o_rom_addr == LAST_ADDR) begin
                state_n = ST_DONE;
            end else begin
                addr_n  = o_rom_addr + ROM_AW'(1);
                state_n = ST_FETCH;
            end
        end
    end

    // Outputs are flops decoded from the next state, so they line up with
    // the state they describe and no input reaches an output combinationally.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            o_rom_addr   <= '0;
            entry        <= '0;
            o_sccb_reg   <= '0;
            o_sccb_val   <= '0;
            o_sccb_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_n;
            o_rom_addr   <= addr_n;
            entry        <= entry_n;
            o_sccb_reg   <= reg_n;
            o_sccb_val   <= val_n;
            o_sccb_valid <= (state_n == ST_SEND);
            o_busy       <= !(state_n inside {ST_IDLE, ST_DONE});
            o_done       <= (state_n == ST_DONE);
        end
    end

endmodule

// File: doc/ov7670_cfg_sequencer.md
# ov7670_cfg_sequencer

Walks a register/value ROM and issues one camera register write per entry to the SCCB master, starting on the `o_cfg_start` pulse from `sys_control`. It sits between `sys_control` and the SCCB master and owns every camera configuration transaction. It inserts a programmed settle delay after the soft-reset entry and signals completion so the capture pipeline can be released.

## Interface
- `ROM_AW`, 8: ROM address width; the ROM holds at most 2^ROM_AW entries.
- `DELAY_CYCLES`, 1_000_000: settle delay in `i_sysclk` cycles, which is 10 ms at 100 MHz.
- `i_sysclk`, in, 1: system clock.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_cfg_start`, in, 1: start pulse, one cycle wide.
- `o_rom_addr`, out, ROM_AW: ROM read address.
- `i_rom_data`, in, 16: the entry {reg[15:8], val[7:0]}, valid exactly 1 cycle after the address is presented.
- `o_sccb_valid`, out, 1: a write request is pending.
- `i_sccb_ready`, in, 1: the SCCB master is idle and accepts a request.
- `o_sccb_reg`, out, 8: camera register address.
- `o_sccb_val`, out, 8: camera register value.
- `i_sccb_done`, in, 1: one-cycle pulse at the end of the bus transaction.
- `o_busy`, out, 1: a sequence is in progress.
- `o_done`, out, 1: level, asserted once the last entry completes; cleared by start or reset.

## Operation
- States: IDLE, FETCH, LATCH, DECODE, SEND, WAIT_DONE, DELAY, DONE.
- **IDLE / DONE:**
  - `i_cfg_start` sets the address to 0 and moves to FETCH.
  - Start is ignored in every other state.
- **FETCH:** presents `o_rom_addr`, then moves to LATCH on the next cycle.
- **LATCH:** registers `i_rom_data` into an entry register, then moves to DECODE.
- **DECODE:**
  - `16'hFFFF` means end of table: go to DONE.
  - `16'hFFF0` means delay: load the counter with DELAY_CYCLES−1 and go to DELAY.
  - Any other value: drive reg/val from the entry register and go to SEND.
- **SEND:**
  - `o_sccb_valid`=1; reg/val are held stable.
  - A transfer occurs in the cycle where valid && ready; then go to WAIT_DONE.
- **WAIT_DONE:**
  - `o_sccb_valid`=0.
  - On `i_sccb_done`, advance the address and go to FETCH.
- **DELAY:** the counter decrements once per cycle; at 0, advance the address and go to FETCH.
- **Address boundary:**
  - If the entry at address 2^ROM_AW−1 completes without a sentinel, go to DONE.
  - The address never wraps to 0.
- **Outputs:**
  - `o_busy`=1 in all states except IDLE and DONE.
  - `o_done`=1 only in DONE.
- **Early done:** `i_sccb_done` arriving during SEND, before the transfer, is ignored.
- **Reset values:** state IDLE, `o_rom_addr`=0, `o_sccb_valid`=0, `o_sccb_reg`=0, `o_sccb_val`=0, `o_busy`=0, `o_done`=0, delay counter 0.
- **Reset mid-sequence:** asserting `i_rstn` low mid-sequence drops `o_sccb_valid` immediately (asynchronously). There is no resume; a new `i_cfg_start` restarts from address 0.

## Timing
- Start pulse at cycle N:
  - FETCH at N+1, LATCH at N+2, DECODE at N+3.
  - `o_sccb_valid` rises at N+4 when the first entry is a write.
- Per-write overhead excluding the bus: 4 cycles from `i_sccb_done` to the next `o_sccb_valid`.
- Delay entry: DELAY lasts exactly DELAY_CYCLES cycles, then FETCH.
- End sentinel: `o_done` rises 1 cycle after DECODE of the sentinel, and `o_busy` falls in the same cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `cam_cfg_pkg`:
  - Sentinel constants `CFG_END`=16'hFFFF and `CFG_DELAY`=16'hFFF0.
  - State encoding localparams.
  - Entry field slice positions.
- ROM contents are kept separately, in the ROM module.
- One natural sub-module: `cfg_delay_counter` (load / decrement / zero flag), parameterised by width clog2(DELAY_CYCLES).

## Test plan
- ROM {1280, FFF0, 1204, FFFF}, DELAY_CYCLES=16, ready tied high, done 20 cycles after each transfer:
  - Writes reg 0x12/val 0x80, then a 16-cycle gap in DELAY, then 0x12/0x04.
  - `o_done`=1; exactly 2 transfers.
- Ready held low for 50 cycles during SEND:
  - `o_sccb_valid`, reg and val stay constant for all 50 cycles.
  - Exactly one transfer when ready rises.
- `i_cfg_start` pulsed while busy (mid-WAIT_DONE):
  - Ignored; address sequence is unchanged.
  - A second start after DONE reruns from address 0 with `o_done` cleared.
- `i_rstn` low during DELAY:
  - All outputs at reset values within the same cycle.
  - No writes after release until the next start.
- 256-entry ROM with no sentinel, ROM_AW=8:
  - 256 transfers, then DONE.
  - `o_rom_addr` never returns to 0 while busy.
- Spurious `i_sccb_done` in SEND: ignored; the transfer count still matches the ROM.
